// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer port arbiter.
// Covers the VGA timing, the 320x240 RGB444 buffer geometry and the clear-engine FSM states.
package fb_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_WORDS = FB_W * FB_H;  // 76800
  localparam int AW       = 17;
  localparam int DW       = 12;

  // Last even column that still needs a read one pair ahead, and the blanking
  // column where the first pair of the next line is fetched.
  localparam int H_LAST_RD  = H_ACTIVE - 2;  // reads issued for h_cnt < 638
  localparam int H_PREFETCH = H_TOTAL - 2;   // 798

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // Linear buffer address of (row, col): row*320 + col.
  function automatic logic [AW-1:0] fb_addr(input logic [8:0] row, input logic [8:0] col);
    return AW'(row) * AW'(FB_W) + AW'(col);
  endfunction

endpackage

// File: rtl/fb_wpost_fifo.sv
// 4-entry write-posting FIFO holding {address, data} pairs for the drawing-engine port.
// Only compiled into the design when FB_WPOST_EN is defined; the default build has no FIFO.
`ifdef FB_WPOST_EN
module fb_wpost_fifo #(
  parameter int W     = 29,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
`endif

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer BRAM scheduler on the 25 MHz pixel clock.
// Display prefetch owns every even active column (and h_cnt=798 ahead of a visible line);
// all other cycles are free slots, given first to the clear engine, then to the writer.
// Optional macro FB_WPOST_EN: places a 4-entry write-posting FIFO in front of the writer.
//
// Writer handshake: wr_req is held with wr_addr/wr_data stable until the cycle in which
// wr_ack is high; that cycle is the transfer. The writer must drop or change its request
// in the following cycle, otherwise it is treated as a new transfer.
module fb_port_arbiter
  import fb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          valid,
  output logic [DW-1:0] pixel,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output fb_state_e     dbg_state
);

  fb_state_e     state;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] clr_col;
  logic          rd_pend;
  logic [DW-1:0] pix_reg;

  logic [9:0]    next_line;
  logic          disp_act;
  logic          disp_pre;
  logic          disp_slot;
  logic          free_slot;
  logic [AW-1:0] disp_addr;
  logic          clr_wr;

  // Writer-side candidate for the current free slot.
  logic          wr_ack_c;
  logic          wr_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  assign next_line = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;
  assign disp_act  = valid && !h_cnt[0] && (h_cnt < 10'(H_LAST_RD));
  assign disp_pre  = (h_cnt == 10'(H_PREFETCH)) && (next_line < 10'(V_ACTIVE));
  assign disp_slot = disp_act || disp_pre;
  assign free_slot = !disp_slot;
  assign disp_addr = disp_pre ? fb_addr(next_line[9:1], 9'd0)
                              : fb_addr(v_cnt[9:1], h_cnt[9:1] + 9'd1);
  assign clr_wr    = (state == CLEAR) && free_slot;
  assign clr_busy  = (state == CLEAR);
  assign dbg_state = state;
  assign pixel     = valid ? pix_reg : '0;

`ifdef FB_WPOST_EN
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [AW+DW-1:0]  fifo_q;

  // Acceptance only depends on space; out-of-range writes are acked but never queued.
  assign wr_ack_c  = wr_req && !fifo_full;
  assign fifo_push = wr_ack_c && (wr_addr < AW'(FB_WORDS));
  assign fifo_pop  = free_slot && (state == IDLE) && !fifo_empty;
  assign wr_we     = fifo_pop;
  assign w_addr    = fifo_q[AW+DW-1:DW];
  assign w_data    = fifo_q[DW-1:0];

  fb_wpost_fifo #(.W(AW + DW), .DEPTH(4)) u_wpost_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({wr_addr, wr_data}),
    .pop   (fifo_pop),
    .dout  (fifo_q),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
`else
  logic wr_grant;

  // Direct handshake: the writer is served only in a free slot the clear engine leaves alone.
  assign wr_grant = free_slot && (state == IDLE) && wr_req;
  assign wr_ack_c = wr_grant;
  assign wr_we    = wr_grant && (wr_addr < AW'(FB_WORDS));
  assign w_addr   = wr_addr;
  assign w_data   = wr_data;
`endif

  // RAM port mux: display read > clear write > writer; everything quiet while in reset.
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    wr_ack   = 1'b0;
    if (rst) begin
      wr_ack = wr_ack_c;
      if (disp_slot) begin
        ram_addr = disp_addr;
      end else if (clr_wr) begin
        ram_addr = clr_cnt;
        ram_we   = 1'b1;
        ram_din  = clr_col;
      end else if (wr_we) begin
        ram_addr = w_addr;
        ram_we   = 1'b1;
        ram_din  = w_data;
      end
    end
  end

  // Clear engine FSM: one word per free slot, back to IDLE after the last word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
      clr_col <= '0;
    end else if (state == IDLE) begin
      if (clr_start) begin
        state   <= CLEAR;
        clr_cnt <= '0;
        clr_col <= clr_color;
      end
    end else if (clr_wr) begin
      if (clr_cnt == AW'(FB_WORDS - 1)) begin
        state   <= IDLE;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Display pipeline: RAM data of a read slot is captured one cycle later into pix_reg.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend <= 1'b0;
      pix_reg <= '0;
    end else begin
      rd_pend <= disp_slot;
      if (rd_pend) pix_reg <= ram_dout;
    end
  end

endmodule
